// File: rtl/roi_serial_driver.sv
// ============================================================================
// Module      : roi_serial_driver
// Description : Host-side driver for the minitest serial harness. It shifts a
//               parallel stimulus vector out on di, issues one load strobe,
//               then captures the ROI result returned on sdo.
//               Optional macro ROI_SERIAL_DRIVER_SDO_SYNC_EN inserts a
//               2-flop synchronizer on sdo, which adds 2 cycles of latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module roi_serial_driver #(
    parameter int DIN_N  = 256,
    parameter int DOUT_N = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIN_N-1:0]  vec_in,
    output logic              busy,
    output logic              done,
    output logic [DOUT_N-1:0] vec_out,
    output logic              di,
    output logic              stb,
    input  logic              sdo
);

    localparam int c_MAX_N = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
    localparam int c_CNT_W = $clog2(c_MAX_N + 1);

`ifdef ROI_SERIAL_DRIVER_SDO_SYNC_EN
    localparam int c_SYNC_LAT = 2;
`else
    localparam int c_SYNC_LAT = 0;
`endif

    // Counter preload values. The edge that leaves WAIT already captures the
    // first result bit, so CAPTURE itself only needs DOUT_N-1 further edges.
    localparam logic [c_CNT_W-1:0] c_CNT_DIN  = c_CNT_W'(DIN_N - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_CAP  = c_CNT_W'(DOUT_N - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_WAIT = c_CNT_W'(c_SYNC_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_STROBE  = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic [DIN_N-1:0]    r_shreg,   w_shreg_nxt;
    logic [DOUT_N-1:0]   r_vec_out, w_vec_out_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_di,      w_di_nxt;
    logic                r_stb,     w_stb_nxt;
    logic                w_sdo_s;

`ifdef ROI_SERIAL_DRIVER_SDO_SYNC_EN
    logic [1:0] r_sdo_sync;

    // Two-flop synchronizer on the returned serial data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdo_sync <= 2'b00;
        end else begin
            r_sdo_sync <= {r_sdo_sync[0], sdo};
        end
    end

    assign w_sdo_s = r_sdo_sync[1];
`else
    assign w_sdo_s = sdo;
`endif

    // State and output register; reset aborts a run with no done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_vec_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_di      <= 1'b0;
            r_stb     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_vec_out <= w_vec_out_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_di      <= w_di_nxt;
            r_stb     <= w_stb_nxt;
        end
    end

    // Next-state and next-output logic for the whole run sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shreg_nxt   = r_shreg;
        w_vec_out_nxt = r_vec_out;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_di_nxt      = 1'b0;
        w_stb_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // MSB goes out immediately; the rest waits in the shifter.
                    w_di_nxt    = vec_in[DIN_N-1];
                    w_shreg_nxt = {vec_in[DIN_N-2:0], 1'b0};
                    w_cnt_nxt   = c_CNT_DIN;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_stb_nxt   = 1'b1;
                    w_state_nxt = S_STROBE;
                end else begin
                    w_di_nxt    = r_shreg[DIN_N-1];
                    w_shreg_nxt = {r_shreg[DIN_N-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt - c_CNT_ONE;
                end
            end
            S_STROBE: begin
                w_cnt_nxt   = c_CNT_WAIT;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_vec_out_nxt = {r_vec_out[DOUT_N-2:0], w_sdo_s};
                    w_cnt_nxt     = c_CNT_CAP;
                    w_state_nxt   = S_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            S_CAPTURE: begin
                w_vec_out_nxt = {r_vec_out[DOUT_N-2:0], w_sdo_s};
                if (r_cnt == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign vec_out = r_vec_out;
    assign di      = r_di;
    assign stb     = r_stb;

endmodule

`default_nettype wire
